// File: rtl/spi_ram_master_if.sv
// Command-side bus of the SPI RAM master: one command in, done/read-data out.
// The host drives the master modport; spi_ram_master takes the slave modport.
interface spi_ram_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] payload;
  logic       ready;
  logic       done;
  logic       rd_valid;
  logic [7:0] rd_data;

  modport master (
    output start, cmd, payload,
    input  ready, done, rd_valid, rd_data
  );

  modport slave (
    input  start, cmd, payload,
    output ready, done, rd_valid, rd_data
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI host for the SPI-slave/RAM wrapper: sends one 10-bit {cmd,payload} frame per command.
// Read-data commands keep clocking through a dummy gap and then shift in one byte from MISO.
module spi_ram_master #(
  parameter int HALF_PERIOD = 2,
  parameter int READ_GAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_ram_master_if.slave   bus,
  output logic              SS_n,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int HW = $clog2(HALF_PERIOD) + 1;
  localparam int GW = (READ_GAP > 0) ? $clog2(READ_GAP + 1) : 1;
  localparam logic [HW-1:0] HP_LAST  = HW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((READ_GAP > 0) ? READ_GAP - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SHIFT,
    ST_GAP,
    ST_READ,
    ST_END
  } state_t;

  state_t          state;
  logic [HW-1:0]   hp_cnt;
  logic [3:0]      bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [9:0]      shreg;
  logic            is_rd;
  logic [7:0]      rx_shift;
  logic            half_done;

  assign half_done = (hp_cnt == HP_LAST);

  // hp_cnt times each SCK half-period; SCK's own level tells high phase from low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hp_cnt       <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      shreg        <= '0;
      is_rd        <= 1'b0;
      rx_shift     <= '0;
      SS_n         <= 1'b1;
      SCK          <= 1'b0;
      MOSI         <= 1'b0;
      bus.ready    <= 1'b1;
      bus.done     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.rd_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.start && bus.ready) begin
            shreg     <= {bus.cmd, bus.payload};
            is_rd     <= &bus.cmd;
            MOSI      <= bus.cmd[1];
            SS_n      <= 1'b0;
            SCK       <= 1'b0;
            bus.ready <= 1'b0;
            hp_cnt    <= '0;
            state     <= ST_ASSERT;
          end
        end

        ST_ASSERT: begin
          if (half_done) begin
            hp_cnt  <= '0;
            bit_cnt <= '0;
            SCK     <= 1'b1;
            state   <= ST_SHIFT;
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
        end

        // Shifting zeros in behind the word leaves MOSI at 0 after the last bit.
        ST_SHIFT: begin
          if (!half_done) begin
            hp_cnt <= hp_cnt + 1'b1;
          end else begin
            hp_cnt <= '0;
            if (SCK) begin
              SCK   <= 1'b0;
              MOSI  <= shreg[8];
              shreg <= {shreg[8:0], 1'b0};
            end else if (bit_cnt != 4'd9) begin
              bit_cnt <= bit_cnt + 1'b1;
              SCK     <= 1'b1;
            end else if (is_rd) begin
              SCK     <= 1'b1;
              bit_cnt <= '0;
              gap_cnt <= '0;
              if (READ_GAP > 0) begin
                state <= ST_GAP;
              end else begin
                rx_shift <= {rx_shift[6:0], MISO};
                state    <= ST_READ;
              end
            end else begin
              SS_n     <= 1'b1;
              SCK      <= 1'b0;
              MOSI     <= 1'b0;
              bus.done <= 1'b1;
              state    <= ST_END;
            end
          end
        end

        ST_GAP: begin
          if (!half_done) begin
            hp_cnt <= hp_cnt + 1'b1;
          end else begin
            hp_cnt <= '0;
            if (SCK) begin
              SCK <= 1'b0;
            end else begin
              SCK <= 1'b1;
              if (gap_cnt == GAP_LAST) begin
                rx_shift <= {rx_shift[6:0], MISO};
                state    <= ST_READ;
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end
        end

        // MISO is captured on the same edge that raises SCK.
        ST_READ: begin
          if (!half_done) begin
            hp_cnt <= hp_cnt + 1'b1;
          end else begin
            hp_cnt <= '0;
            if (SCK) begin
              SCK <= 1'b0;
            end else if (bit_cnt != 4'd7) begin
              bit_cnt  <= bit_cnt + 1'b1;
              SCK      <= 1'b1;
              rx_shift <= {rx_shift[6:0], MISO};
            end else begin
              SS_n         <= 1'b1;
              MOSI         <= 1'b0;
              bus.done     <= 1'b1;
              bus.rd_valid <= 1'b1;
              bus.rd_data  <= rx_shift;
              state        <= ST_END;
            end
          end
        end

        ST_END: begin
          if (half_done) begin
            hp_cnt    <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            bus.ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
